// File: rtl/alu_defs.sv
// Shared ALU definitions: equality FSM encodings, default operand width and
// the equality result-vector layout.
package alu_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } eq_state_t;

  localparam int ALU_WIDTH = 3;

  // The all-bits-equal flag sits directly above the per-bit field.
  function automatic int eq_all_bit(input int width);
    return width;
  endfunction

endpackage

// File: rtl/eq_bit_cell.sv
// One-bit equality cell (XNOR) used on the bit currently selected by the
// serial compare.
module eq_bit_cell (
  input  logic a_bit,
  input  logic b_bit,
  output logic eq_bit
);

  assign eq_bit = ~(a_bit ^ b_bit);

endmodule

// File: rtl/serial_equality_unit.sv
// Handshaked bit-serial equality compare, LSB first, one bit per clock.
// Optional macro SERIAL_EQ_BACK_TO_BACK_EN lets DONE accept the next pair on the release edge.
module serial_equality_unit
  import alu_defs::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   equal,
  output logic             busy
);

  localparam int                IDX_W      = $clog2(WIDTH);
  localparam int                EQ_ALL_BIT = eq_all_bit(WIDTH);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(WIDTH - 1);

  eq_state_t        r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH:0]   r_result;
  logic [IDX_W-1:0] r_idx;
  logic             r_out_valid;
  logic             r_busy;

  logic w_a_bit;
  logic w_b_bit;
  logic w_eq_bit;
  logic w_accept;
  logic w_release;

  assign w_a_bit = r_a[r_idx];
  assign w_b_bit = r_b[r_idx];

  eq_bit_cell u_eq_bit_cell (
    .a_bit  (w_a_bit),
    .b_bit  (w_b_bit),
    .eq_bit (w_eq_bit)
  );

  always_comb begin
    in_ready = 1'b0;
    case (r_state)
      ST_IDLE: in_ready = 1'b1;
`ifdef SERIAL_EQ_BACK_TO_BACK_EN
      ST_DONE: in_ready = out_ready;
`endif
      default: in_ready = 1'b0;
    endcase
  end

  assign w_accept  = in_valid && in_ready;
  assign w_release = r_out_valid && out_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  // Partial results stay hidden; the vector only appears while the result is offered.
  assign equal     = r_out_valid ? r_result : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_result    <= '0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_result <= '0;
            r_idx    <= '0;
            r_busy   <= 1'b1;
            r_state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_result[r_idx] <= w_eq_bit;
          if (r_idx == LAST_IDX) begin
            // Lower bits are all final by now; fold in the bit computed this cycle.
            r_result[EQ_ALL_BIT] <= w_eq_bit & (&r_result[WIDTH-2:0]);
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (w_release) begin
            r_out_valid <= 1'b0;
            // w_accept can only be set here when back-to-back acceptance is built in.
            if (w_accept) begin
              r_a      <= a;
              r_b      <= b;
              r_result <= '0;
              r_idx    <= '0;
              r_busy   <= 1'b1;
              r_state  <= ST_SHIFT;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_equality_unit.sv
// Self-checking bench for serial_equality_unit against a whole-word equality model.
module tb_serial_equality_unit;

  localparam int W = 3;
`ifdef SERIAL_EQ_BACK_TO_BACK_EN
  localparam int PULSE_GAP = W + 1;
`else
  localparam int PULSE_GAP = W + 2;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic         busy;
  logic [W:0]   equal;

  int errors = 0;
  int checks = 0;

  serial_equality_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .equal     (equal),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference: per-bit match flags plus whole-word equality on top.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] r;
    for (int i = 0; i < W; i++) r[i] = (x[i] == y[i]);
    r[W] = (x == y);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one compare with out_ready high; lat counts edges after the acceptance edge.
  task automatic run_one(input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W:0] got, output int lat);
    a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    got = equal;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || equal !== '0)
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b equal=%b required 1 0 0 0000",
               in_ready, out_valid, busy, equal);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || equal !== '0) begin
      errors++;
      $display("FAIL post_reset_idle: in_ready=%b out_valid=%b busy=%b equal=%b", in_ready, out_valid, busy, equal);
    end
  endtask

  task automatic test_match();
    int lat;
    a = 3'b101; b = 3'b101; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    a = W'($urandom); b = ~a;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 || equal !== '0) begin
      errors++;
      $display("FAIL match_shift_flags: busy=%b in_ready=%b out_valid=%b equal=%b", busy, in_ready, out_valid, equal);
    end
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    // acceptance edge plus W shift edges
    checks++;
    if (lat !== W) begin
      errors++;
      $display("FAIL match_latency: got %0d edges after acceptance, required %0d", lat, W);
    end
    checks++;
    if (equal !== 4'b1111) begin
      errors++;
      $display("FAIL match_result: got %b required 1111", equal);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || equal !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL match_release: out_valid=%b in_ready=%b equal=%b busy=%b", out_valid, in_ready, equal, busy);
    end
  endtask

  task automatic test_mismatch();
    logic [W-1:0] ta [2];
    logic [W-1:0] tb [2];
    logic [W:0]   te [2];
    logic [W:0]   got;
    int lat;
    ta[0] = 3'b101; tb[0] = 3'b100; te[0] = 4'b0110;
    ta[1] = 3'b000; tb[1] = 3'b111; te[1] = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      run_one(ta[i], tb[i], got, lat);
      checks++;
      if (got !== te[i] || lat !== W) begin
        errors++;
        $display("FAIL mismatch_%0d: got %b lat %0d required %b lat %0d", i, got, lat, te[i], W);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] x, y;
    logic [W:0]   got;
    int lat;
    for (int i = 0; i < 24; i++) begin
      x = W'($urandom);
      y = ($urandom_range(0, 1) == 1) ? x : W'($urandom);
      run_one(x, y, got, lat);
      checks++;
      if (got !== model(x, y) || lat !== W) begin
        errors++;
        $display("FAIL random_%0d: a=%b b=%b got %b lat %0d required %b lat %0d",
                 i, x, y, got, lat, model(x, y), W);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    a = 3'b011; b = 3'b011; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    in_valid = 1'b1; a = 3'b000; b = 3'b111;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || equal !== 4'b1111 || in_ready !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold_%0d: out_valid=%b equal=%b in_ready=%b busy=%b required 1 1111 0 0",
                 i, out_valid, equal, in_ready, busy);
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b busy=%b required 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_isolation();
    int lat;
    a = 3'b110; b = 3'b100; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    lat = 0;
    while (!out_valid && lat < 50) begin
      a = W'($urandom); b = W'($urandom); in_valid = ~in_valid;
      tick();
      lat++;
    end
    in_valid = 1'b0;
    checks++;
    if (equal !== model(3'b110, 3'b100) || lat !== W) begin
      errors++;
      $display("FAIL isolation_result: got %b lat %0d required %b lat %0d", equal, lat, model(3'b110, 3'b100), W);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL isolation_no_extra: busy=%b out_valid=%b required 0 0", busy, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] x;
    logic [W:0]   got;
    int lat;
    a = 3'b111; b = 3'b111; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || equal !== '0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_async: out_valid=%b equal=%b busy=%b in_ready=%b required 0 0000 0 1",
               out_valid, equal, busy, in_ready);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    x = W'($urandom);
    run_one(x, x ^ 3'b010, got, lat);
    checks++;
    if (got !== model(x, x ^ 3'b010) || lat !== W) begin
      errors++;
      $display("FAIL reset_mid_recover: got %b lat %0d required %b lat %0d", got, lat, model(x, x ^ 3'b010), W);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, n, t1, t2;
    logic [W:0] e1, e2;
    a = 3'b111; b = 3'b111; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    a = 3'b010; b = 3'b011;
    n = 0; cyc = 0; t1 = 0; t2 = 0; e1 = '0; e2 = '0;
    while (n < 2 && cyc < 40) begin
      tick();
      cyc++;
      if (out_valid) begin
        if (n == 0) begin t1 = cyc; e1 = equal; end
        else begin t2 = cyc; e2 = equal; end
        n++;
      end
      if (n > 0 && busy) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (e1 !== 4'b1111 || t1 !== W) begin
      errors++;
      $display("FAIL b2b_first: got %b at %0d required 1111 at %0d", e1, t1, W);
    end
    checks++;
    if (e2 !== 4'b0110) begin
      errors++;
      $display("FAIL b2b_second: got %b required 0110", e2);
    end
    checks++;
    if (t2 - t1 !== PULSE_GAP) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d cycles required %0d", t2 - t1, PULSE_GAP);
    end
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_backpressure();
    test_isolation();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
